// File: rtl/uart_bus_device.sv
// uart_bus_device: 8N1 UART with a strobe-driven host bus.
//   clk, rst            : single clock, synchronous active-high reset
//   wrn, rdn            : active-low host write / read strobes (acted on at rising edge)
//   data                : shared 8-bit host bus; driven with RBR while rdn=0 and wrn=1
//   data_ready          : a received byte is waiting in RBR
//   tbre, tsre          : transmit holding register empty / transmit shifter idle
//   txd, rxd            : serial lines, idle high (rxd is asynchronous)
// Optional build macro UART_BUS_LOOPBACK_EN: the receiver listens to the internal
// transmit bit, txd is held high and rxd is ignored.
module uart_bus_device #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrn,
  input  logic       rdn,
  inout  wire  [7:0] data,
  output logic       data_ready,
  output logic       tbre,
  output logic       tsre,
  output logic       txd,
  input  logic       rxd
);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          tx_state, tx_state_n, rx_state, rx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n, rx_bit, rx_bit_n;
  logic            tx_load, tx_shift, tx_done, rx_shift, rx_load;
  logic            wrn_q, rdn_q, wr_rise, rd_rise;
  logic [7:0]      wr_latch, thr, tsr, rbr, rx_sr;
  logic            tx_line, rx_src, rx_s1, rx_s2, rx_prev;

  assign wr_rise = !wrn_q && wrn;
  assign rd_rise = !rdn_q && rdn;

  always_comb begin
    tx_line = 1'b1;
    case (tx_state)
      S_START: tx_line = 1'b0;
      S_DATA:  tx_line = tsr[0];
      default: tx_line = 1'b1;
    endcase
  end

`ifdef UART_BUS_LOOPBACK_EN
  logic unused_rxd;
  assign unused_rxd = rxd;
  assign rx_src     = tx_line;
  assign txd        = 1'b1;
`else
  assign rx_src = rxd;
  assign txd    = tx_line;
`endif

  assign data = (!rst && !rdn && wrn) ? rbr : 'z;

  // Transmitter: at the end of STOP a pending THR is loaded straight into START,
  // so back-to-back frames have no idle gap and tsre never rises in between.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    tx_done    = 1'b0;
    case (tx_state)
      S_IDLE: begin
        if (!tbre) begin
          tx_load    = 1'b1;
          tx_state_n = S_START;
          tx_cnt_n   = '0;
        end
      end
      S_START: begin
        if (tx_cnt == CNT_LAST) begin
          tx_state_n = S_DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      S_DATA: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          tx_shift = 1'b1;
          if (tx_bit == 3'd7) tx_state_n = S_STOP;
          else tx_bit_n = tx_bit + 3'd1;
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      S_STOP: begin
        if (tx_cnt == CNT_LAST) begin
          tx_cnt_n = '0;
          if (!tbre) begin
            tx_load    = 1'b1;
            tx_state_n = S_START;
          end else begin
            tx_done    = 1'b1;
            tx_state_n = S_IDLE;
          end
        end else tx_cnt_n = tx_cnt + 1'b1;
      end
      default: tx_state_n = S_IDLE;
    endcase
  end

  // Receiver: start bit is confirmed at its centre, which also aligns every
  // later sample to a bit centre after one full bit period.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift   = 1'b0;
    rx_load    = 1'b0;
    case (rx_state)
      S_IDLE: begin
        if (rx_prev && !rx_s2) begin
          rx_state_n = S_START;
          rx_cnt_n   = '0;
        end
      end
      S_START: begin
        if (rx_cnt == CNT_HALF) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      S_DATA: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n = '0;
          rx_shift = 1'b1;
          if (rx_bit == 3'd7) rx_state_n = S_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      S_STOP: begin
        if (rx_cnt == CNT_LAST) begin
          rx_cnt_n   = '0;
          rx_load    = rx_s2;
          rx_state_n = S_IDLE;
        end else rx_cnt_n = rx_cnt + 1'b1;
      end
      default: rx_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state   <= S_IDLE;
      rx_state   <= S_IDLE;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tx_bit     <= '0;
      rx_bit     <= '0;
      wrn_q      <= 1'b1;
      rdn_q      <= 1'b1;
      wr_latch   <= '0;
      thr        <= '0;
      tsr        <= '0;
      rbr        <= '0;
      rx_sr      <= '0;
      tbre       <= 1'b1;
      tsre       <= 1'b1;
      data_ready <= 1'b0;
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      rx_state <= rx_state_n;
      tx_cnt   <= tx_cnt_n;
      rx_cnt   <= rx_cnt_n;
      tx_bit   <= tx_bit_n;
      rx_bit   <= rx_bit_n;
      wrn_q    <= wrn;
      rdn_q    <= rdn;
      rx_s1    <= rx_src;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      if (!wrn) wr_latch <= data;
      // tx_load needs tbre=0 and a write is accepted only with tbre=1.
      if (tx_load) begin
        tsr  <= thr;
        tbre <= 1'b1;
        tsre <= 1'b0;
      end else if (wr_rise && tbre) begin
        thr  <= wr_latch;
        tbre <= 1'b0;
      end
      if (tx_shift) tsr <= {1'b0, tsr[7:1]};
      if (tx_done) tsre <= 1'b1;
      if (rx_shift) rx_sr <= {rx_s2, rx_sr[7:1]};
      if (rx_load) begin
        rbr        <= rx_sr;
        data_ready <= 1'b1;
      end else if (rd_rise) begin
        data_ready <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_bus_device.sv
// Self-checking bench for uart_bus_device at CLKS_PER_BIT=4.
module tb_uart_bus_device;
  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic rst, wrn, rdn, rxd;
  logic data_ready, tbre, tsre, txd;
  wire  [7:0] data;
  logic       drv_en;
  logic [7:0] drv_val;
  assign data = drv_en ? drv_val : 'z;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state: expected receive buffer and flag, expected tx frames.
  logic [7:0] exp_rbr;
  logic       exp_ready;
  logic [7:0] tx_q[$];

  uart_bus_device #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .wrn(wrn), .rdn(rdn), .data(data),
    .data_ready(data_ready), .tbre(tbre), .tsre(tsre), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Serial frame: index 0 start (0), 1..8 data LSB first, 9 stop (1).
  function automatic logic frame_bit(input logic [7:0] b, input int unsigned i);
    if (i == 0) return 1'b0;
    if (i == 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic write_byte(input logic [7:0] b);
    drv_val = b;
    drv_en  = 1'b1;
    wrn     = 1'b0;
    tick();
    wrn     = 1'b1;
    drv_en  = 1'b0;
    tick();
  endtask

  task automatic check_tx(input int unsigned n);
    int unsigned w = 0;
    while (txd !== 1'b0 && w < 200) begin
      tick();
      w++;
    end
    check("tx_start_seen", {31'b0, txd}, 32'd0);
    for (int unsigned f = 0; f < n; f++) begin
      logic [7:0] b;
      b = (tx_q.size() > 0) ? tx_q.pop_front() : 8'h00;
      for (int unsigned i = 0; i < 10; i++) begin
        for (int unsigned c = 0; c < CPB; c++) begin
          check("txd_bit", {31'b0, txd}, {31'b0, frame_bit(b, i)});
          if (c == 0) check("tsre_busy", {31'b0, tsre}, 32'd0);
          tick();
        end
      end
    end
    check("tsre_done", {31'b0, tsre}, 32'd1);
    check("txd_idle", {31'b0, txd}, 32'd1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    for (int unsigned i = 0; i < 10; i++) begin
      rxd = (i == 9) ? stop : frame_bit(b, i);
      repeat (CPB) tick();
    end
    rxd = 1'b1;
    if (stop) begin
      exp_rbr   = b;
      exp_ready = 1'b1;
    end
  endtask

  task automatic read_check(input string tag);
    rdn = 1'b0;
    tick();
    check(tag, {24'b0, data}, {24'b0, exp_rbr});
    rdn = 1'b1;
    tick();
    exp_ready = 1'b0;
    check("rd_clears_ready", {31'b0, data_ready}, {31'b0, exp_ready});
    // With the DUT released the bus must read back what the bench drives.
    drv_val = 8'h00;
    drv_en  = 1'b1;
    #1;
    check("bus_released", {24'b0, data}, 32'd0);
    drv_en  = 1'b0;
  endtask

  initial begin
    logic [7:0] b_tx, b_rx;
    int unsigned w;
    rst = 1'b1; wrn = 1'b1; rdn = 1'b1; rxd = 1'b1;
    drv_en = 1'b0; drv_val = 8'h00;
    exp_rbr = 8'h00; exp_ready = 1'b0;
    repeat (3) tick();
    check("rst_txd", {31'b0, txd}, 32'd1);
    check("rst_tbre", {31'b0, tbre}, 32'd1);
    check("rst_tsre", {31'b0, tsre}, 32'd1);
    check("rst_ready", {31'b0, data_ready}, 32'd0);
    rst = 1'b0;
    tick();

`ifdef UART_BUS_LOOPBACK_EN
    rxd = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b_tx = (k == 0) ? 8'h81 : 8'($urandom_range(0, 255));
      write_byte(b_tx);
      w = 0;
      while (data_ready !== 1'b1 && w < 120) begin
        check("lb_txd_high", {31'b0, txd}, 32'd1);
        tick();
        w++;
      end
      exp_rbr = b_tx;
      check("lb_ready", {31'b0, data_ready}, 32'd1);
      read_check("lb_read");
      repeat (10) tick();
    end
`else
    // Single frame
    tx_q.push_back(8'hA5);
    write_byte(8'hA5);
    check("tbre_after_write", {31'b0, tbre}, 32'd0);
    tick();
    check("tbre_on_shift", {31'b0, tbre}, 32'd1);
    check_tx(1);

    // Back-to-back frames, third write dropped while THR is full
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'h3C);
    write_byte(8'hA5);
    fork
      check_tx(2);
      begin
        repeat (6) tick();
        write_byte(8'h3C);
        check("tbre_full", {31'b0, tbre}, 32'd0);
        repeat (4) tick();
        write_byte(8'h77);
        check("tbre_still_full", {31'b0, tbre}, 32'd0);
      end
    join
    for (int i = 0; i < 24; i++) begin
      check("dropped_write_idle", {31'b0, txd}, 32'd1);
      tick();
    end
    check("tbre_idle", {31'b0, tbre}, 32'd1);

    // Receive and read
    send_frame(8'h5A, 1'b1);
    repeat (4) tick();
    check("rx_ready", {31'b0, data_ready}, {31'b0, exp_ready});
    read_check("rx_5a");

    // Glitch and framing error
    rxd = 1'b0;
    tick();
    rxd = 1'b1;
    repeat (50) tick();
    check("glitch_no_byte", {31'b0, data_ready}, 32'd0);
    send_frame(8'hFF, 1'b0);
    repeat (4) tick();
    check("framing_no_byte", {31'b0, data_ready}, 32'd0);
    read_check("rbr_kept");

    // Overwrite while unread
    send_frame(8'h11, 1'b1);
    repeat (4) tick();
    send_frame(8'h22, 1'b1);
    repeat (4) tick();
    check("overwrite_ready", {31'b0, data_ready}, 32'd1);
    read_check("overwrite_rbr");

    // Concurrent random traffic in both directions
    for (int k = 0; k < 6; k++) begin
      b_tx = 8'($urandom_range(0, 255));
      b_rx = 8'($urandom_range(0, 255));
      tx_q.push_back(b_tx);
      fork
        begin write_byte(b_tx); check_tx(1); end
        begin send_frame(b_rx, 1'b1); repeat (4) tick(); end
      join
      check("rand_ready", {31'b0, data_ready}, {31'b0, exp_ready});
      read_check("rand_rx");
    end

    // Reset in mid-frame
    send_frame(8'h96, 1'b1);
    repeat (4) tick();
    write_byte(8'hA5);
    repeat (15) tick();
    rst = 1'b1;
    tick();
    check("midrst_txd", {31'b0, txd}, 32'd1);
    check("midrst_tbre", {31'b0, tbre}, 32'd1);
    check("midrst_tsre", {31'b0, tsre}, 32'd1);
    check("midrst_ready", {31'b0, data_ready}, 32'd0);
    rst = 1'b0;
    exp_rbr = 8'h00;
    exp_ready = 1'b0;
    tx_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_idle", {31'b0, txd}, 32'd1);
    end
    read_check("post_rst_rbr");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
